// File: rtl/jsv_pio_pkg.sv
// Shared constants for the jsv input PIO: the Avalon register map and the
// edge-capture modes.
package jsv_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum int unsigned {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/jsv_pio_debounce.sv
// Single-bit input conditioner: two-flop synchronizer followed by a
// consecutive-cycle debounce counter and the accepted (stable) value.
module jsv_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic sync_meta;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= RESET_BIT;
      sync_q    <= RESET_BIT;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout <= RESET_BIT;
        end else begin
          dout <= sync_q;
        end
      end
    end else begin : g_count
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;

      // Any cycle where the synced bit agrees with the accepted value restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt  <= '0;
          dout <= RESET_BIT;
        end else if (sync_q == dout) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          dout <= sync_q;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/jsv_key_switch_pio.sv
// Avalon-MM input PIO for board keys/switches: per-bit sync + debounce,
// edge capture with write-1-to-clear, and a masked level interrupt.
module jsv_key_switch_pio
  import jsv_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = 4'hF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jsv_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_BIT      (RESET_VALUE[i])
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[i]),
        .dout   (stable[i])
      );
    end

    if (WIDTH < 32) begin : g_wdata_upper
      logic unused_wdata_upper;
      assign unused_wdata_upper = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wr_en = chipselect && !write_n;

  always_comb begin
    edge_bits = stable ^ stable_q;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_bits = stable & ~stable_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_bits = ~stable & stable_q;
    end
  end

  always_comb begin
    clr_bits = '0;
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      clr_bits = writedata[WIDTH-1:0];
    end
  end

  // A new edge is OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q    <= RESET_VALUE;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      stable_q    <= stable;
      edgecapture <= (edgecapture & ~clr_bits) | edge_bits;
      if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(edgecapture & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecapture;
      default:          readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_jsv_key_switch_pio.sv
// Directed self-checking bench for jsv_key_switch_pio at default parameters.
module tb_jsv_key_switch_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int unsigned total;
  int unsigned bad;

  jsv_key_switch_pio dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1ns after the last one.
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // 1. reset state and read-only data register
    tick(3);
    reset_n = 1'b1;
    tick(1);
    rd(2'd0, d); chk("rst_addr0", d, 32'h0000_000F);
    rd(2'd1, d); chk("rst_addr1", d, 32'h0);
    rd(2'd2, d); chk("rst_addr2", d, 32'h0);
    rd(2'd3, d); chk("rst_addr3", d, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    wr(2'd0, 32'h5);
    rd(2'd0, d); chk("ro_addr0", d, 32'h0000_000F);

    // 2. three-cycle glitch is rejected
    tick(1);
    in_port = 4'hE;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd(2'd0, d); chk("glitch_addr0", d, 32'hF);
    rd(2'd3, d); chk("glitch_edge", d, 32'h0);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // 3. held press: data after 6 edges, capture after 7
    tick(1);
    in_port = 4'hE;
    tick(5);
    rd(2'd0, d); chk("press_addr0_c5", d, 32'hF);
    tick(1);
    rd(2'd0, d); chk("press_addr0_c6", d, 32'hE);
    rd(2'd3, d); chk("press_edge_c6", d, 32'h0);
    tick(1);
    rd(2'd3, d); chk("press_edge_c7", d, 32'h1);
    chk("press_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'hFFFF_FFF1);
    rd(2'd2, d); chk("mask_rd", d, 32'h1);
    chk("press_irq_unmasked", {31'b0, irq}, 32'h1);

    // 4. write-1-to-clear, and rising edges are not captured
    wr(2'd3, 32'h0);
    rd(2'd3, d); chk("clr0_edge", d, 32'h1);
    chk("clr0_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    rd(2'd3, d); chk("clr1_edge", d, 32'h0);
    chk("clr1_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    tick(10);
    rd(2'd0, d); chk("release_addr0", d, 32'hF);
    rd(2'd3, d); chk("release_edge", d, 32'h0);
    chk("release_irq", {31'b0, irq}, 32'h0);

    // 5. clear lands on the same edge as the capture: set wins
    in_port = 4'hE;
    tick(6);
    wr(2'd3, 32'h1);
    rd(2'd3, d); chk("collide_edge", d, 32'h1);
    chk("collide_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    rd(2'd3, d); chk("postcollide_edge", d, 32'h0);

    // 6. reset mid-debounce
    tick(1);
    in_port = 4'h0;
    tick(4);
    reset_n = 1'b0;
    #1;
    rd(2'd0, d); chk("midrst_addr0", d, 32'hF);
    reset_n = 1'b1;
    rd(2'd0, d); chk("after_rst_addr0", d, 32'hF);
    rd(2'd2, d); chk("after_rst_mask", d, 32'h0);
    rd(2'd3, d); chk("after_rst_edge", d, 32'h0);
    tick(5);
    rd(2'd0, d); chk("after_rst_addr0_c5", d, 32'hF);
    tick(1);
    rd(2'd0, d); chk("after_rst_addr0_c6", d, 32'h0);
    rd(2'd3, d); chk("after_rst_edge_c6", d, 32'h0);
    tick(1);
    rd(2'd3, d); chk("after_rst_edge_c7", d, 32'hF);
    chk("after_rst_irq", {31'b0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
